// File: rtl/q_hidden_layer_mac.sv
// First fully-connected hidden layer of the DQN forward path: h = ReLU(W*x + b),
// evaluated serially through one shared multiplier, one MAC per cycle.
module q_hidden_layer_mac #(
    parameter int N_HID = 9,
    parameter int DW    = 16,
    parameter int FRAC  = 10,
    parameter int ACC_W = 40
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [DW-1:0]                   in_layer_1,
    input  logic [DW-1:0]                   in_layer_2,
    input  logic [DW-1:0]                   in_layer_3,
    input  logic [DW-1:0]                   in_layer_4,
    input  logic [DW-1:0]                   in_layer_5,
    input  logic [DW-1:0]                   in_layer_6,
    input  logic [DW-1:0]                   in_layer_7,
    input  logic [DW-1:0]                   in_layer_8,
    input  logic [DW-1:0]                   in_layer_9,
    input  logic                            w_we,
    input  logic [$clog2(N_HID*9)-1:0]      w_addr,
    input  logic [DW-1:0]                   w_data,
    input  logic                            b_we,
    input  logic [$clog2(N_HID)-1:0]        b_addr,
    input  logic [DW-1:0]                   b_data,
    output logic                            busy,
    output logic                            done,
    output logic [N_HID*DW-1:0]             h_out
);
    localparam int N_IN = 9;
    localparam int N_W  = N_HID * N_IN;
    localparam int WAW  = $clog2(N_W);
    localparam int JW   = $clog2(N_HID);
    localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
    state_t state, state_nxt;

    logic signed [DW-1:0]    w_mem [N_W];
    logic signed [DW-1:0]    b_mem [N_HID];
    logic signed [DW-1:0]    x_reg [N_IN];
    logic        [DW-1:0]    h_reg [N_HID];
    logic signed [ACC_W-1:0] acc;
    logic        [3:0]       i;
    logic        [JW-1:0]    j;
    logic        [WAW-1:0]   w_idx;

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] y;
    logic        [DW-1:0]    y_relu;
    logic        [JW-1:0]    j_inc;

    function automatic logic signed [ACC_W-1:0] bias_acc(input logic signed [DW-1:0] b);
        return {{(ACC_W-DW){b[DW-1]}}, b} <<< FRAC;
    endfunction

    // w_idx walks j*9+i linearly, so no address multiplier is needed
    assign prod     = x_reg[i] * w_mem[w_idx];
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign y        = acc >>> FRAC;
    assign j_inc    = j + JW'(1);

    always_comb begin
        if (y < 0)          y_relu = '0;
        else if (y > Y_MAX) y_relu = Y_MAX[DW-1:0];
        else                y_relu = y[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (i == 4'(N_IN - 1)) state_nxt = WB;
            WB:      state_nxt = (j == JW'(N_HID - 1)) ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_W; k++)   w_mem[k] <= '0;
            for (int k = 0; k < N_HID; k++) b_mem[k] <= '0;
            for (int k = 0; k < N_HID; k++) h_reg[k] <= '0;
            for (int k = 0; k < N_IN; k++)  x_reg[k] <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            w_idx <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Arrays are writable only here so they stay stable for a whole pass
                    if (w_we && (w_addr < WAW'(N_W)))  w_mem[w_addr] <= w_data;
                    if (b_we && (b_addr < JW'(N_HID))) b_mem[b_addr] <= b_data;
                    if (start) begin
                        x_reg[0] <= in_layer_1;
                        x_reg[1] <= in_layer_2;
                        x_reg[2] <= in_layer_3;
                        x_reg[3] <= in_layer_4;
                        x_reg[4] <= in_layer_5;
                        x_reg[5] <= in_layer_6;
                        x_reg[6] <= in_layer_7;
                        x_reg[7] <= in_layer_8;
                        x_reg[8] <= in_layer_9;
                        acc   <= bias_acc(b_mem[0]);
                        i     <= '0;
                        j     <= '0;
                        w_idx <= '0;
                        busy  <= 1'b1;
                    end
                end
                MAC: begin
                    acc   <= acc + prod_ext;
                    i     <= i + 4'd1;
                    w_idx <= w_idx + WAW'(1);
                end
                WB: begin
                    h_reg[j] <= y_relu;
                    if (j != JW'(N_HID - 1)) begin
                        j   <= j_inc;
                        i   <= '0;
                        acc <= bias_acc(b_mem[j_inc]);
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_HID; g++) begin : g_hout
        assign h_out[g*DW +: DW] = h_reg[g];
    end
endmodule

// File: tb/tb_q_hidden_layer_mac.sv
// Directed bench for q_hidden_layer_mac: a reference model predicts each pass's
// activations into a queue, which is popped and compared when done pulses.
module tb_q_hidden_layer_mac;
    localparam int N_HID = 9, DW = 16, HW = N_HID * DW;

    logic          clk, rst_n, start, w_we, b_we, busy, done;
    logic [DW-1:0] in_layer_1, in_layer_2, in_layer_3, in_layer_4, in_layer_5;
    logic [DW-1:0] in_layer_6, in_layer_7, in_layer_8, in_layer_9;
    logic [6:0]    w_addr;
    logic [3:0]    b_addr;
    logic [DW-1:0] w_data, b_data;
    logic [HW-1:0] h_out;

    q_hidden_layer_mac dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_layer_1(in_layer_1), .in_layer_2(in_layer_2), .in_layer_3(in_layer_3),
        .in_layer_4(in_layer_4), .in_layer_5(in_layer_5), .in_layer_6(in_layer_6),
        .in_layer_7(in_layer_7), .in_layer_8(in_layer_8), .in_layer_9(in_layer_9),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .busy(busy), .done(done), .h_out(h_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [DW-1:0] mw [81];
    logic signed [DW-1:0] mb [9];
    logic signed [DW-1:0] mx [9];
    logic [HW-1:0]        exp_q [$];

    task automatic chk(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [HW-1:0] model_h();
        logic [HW-1:0] r;
        longint acc, y;
        r = '0;
        for (int jj = 0; jj < N_HID; jj++) begin
            acc = longint'(mb[jj]) * 1024;
            for (int ii = 0; ii < 9; ii++) acc += longint'(mx[ii]) * longint'(mw[jj*9+ii]);
            y = acc >>> 10;
            if (y < 0) y = 0;
            if (y > 32767) y = 32767;
            r[jj*DW +: DW] = DW'(y);
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 81; k++) mw[k] = '0;
        for (int k = 0; k < 9; k++) mb[k] = '0;
    endtask

    task automatic drive_x();
        in_layer_1 = mx[0]; in_layer_2 = mx[1]; in_layer_3 = mx[2];
        in_layer_4 = mx[3]; in_layer_5 = mx[4]; in_layer_6 = mx[5];
        in_layer_7 = mx[6]; in_layer_8 = mx[7]; in_layer_9 = mx[8];
    endtask

    task automatic scramble_x();
        in_layer_1 = DW'($urandom); in_layer_2 = DW'($urandom); in_layer_3 = DW'($urandom);
        in_layer_4 = DW'($urandom); in_layer_5 = DW'($urandom); in_layer_6 = DW'($urandom);
        in_layer_7 = DW'($urandom); in_layer_8 = DW'($urandom); in_layer_9 = DW'($urandom);
    endtask

    // One IDLE-cycle write of a weight and/or a bias
    task automatic wr(input bit dw, input int wa, input logic [DW-1:0] wd,
                      input bit db, input int ba, input logic [DW-1:0] bd);
        w_we = dw; w_addr = 7'(wa); w_data = wd;
        b_we = db; b_addr = 4'(ba); b_data = bd;
        @(posedge clk); #1;
        w_we = 1'b0; b_we = 1'b0;
        if (dw && wa < 81) mw[wa] = wd;
        if (db && ba < 9)  mb[ba] = bd;
    endtask

    // k counts edges after the one that samples start; 0 disables an injection
    task automatic run_pass(input int again_k, input int wr_k, input int rst_k);
        bit aborted;
        logic [HW-1:0] e;
        aborted = 1'b0;
        drive_x();
        start = 1'b1;
        exp_q.push_back(model_h());
        @(posedge clk); #1;
        start = 1'b0;
        scramble_x();
        for (int k = 1; k <= 110; k++) begin
            if (k == again_k) start = 1'b1;
            if (k == wr_k) begin w_we = 1'b1; w_addr = 7'd4; w_data = '0; end
            if (k == rst_k + 2 && aborted) rst_n = 1'b1;
            if (k == rst_k) begin
                #3 rst_n = 1'b0;
                #1;
                chk("abort_busy", HW'(busy), '0);
                chk("abort_h_out", h_out, '0);
                clear_model();
                aborted = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            w_we  = 1'b0;
            if (aborted) chk("abort_no_done", HW'(done), '0);
            else begin
                if (k <= 90) chk($sformatf("busy_k%0d", k), HW'(busy), HW'(1));
                chk($sformatf("done_k%0d", k), HW'(done), HW'(k == 91));
                if (k == 91) begin
                    chk("busy_at_done", HW'(busy), '0);
                    e = exp_q.pop_front();
                    chk("h_out", h_out, e);
                end
            end
        end
        if (aborted) void'(exp_q.pop_front());
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; w_we = 1'b0; b_we = 1'b0;
        w_addr = '0; w_data = '0; b_addr = '0; b_data = '0;
        for (int k = 0; k < 9; k++) mx[k] = '0;
        clear_model();
        drive_x();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", HW'(busy), '0);
        chk("rst_done", HW'(done), '0);
        chk("rst_h_out", h_out, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero pass
        mx[4] = 16'h0400;
        run_pass(0, 0, 0);
        chk("s1_zero", h_out, '0);

        // Positive path, weight and bias written in the same cycle
        wr(1'b1, 4, 16'h0800, 1'b1, 0, 16'h0200);
        run_pass(0, 0, 0);
        chk("s2_h0", HW'(h_out[15:0]), HW'(16'h0A00));
        chk("s2_rest", HW'(h_out[HW-1:16]), '0);

        // ReLU clamp
        wr(1'b1, 13, 16'hF800, 1'b1, 1, 16'h0100);
        run_pass(0, 0, 0);
        chk("s3_h1", HW'(h_out[31:16]), '0);
        chk("s3_h0", HW'(h_out[15:0]), HW'(16'h0A00));

        // Saturation, negative bias, and dropped out-of-range writes
        for (int k = 0; k < 9; k++) mx[k] = 16'h7C00;
        for (int k = 0; k < 9; k++) wr(1'b1, 18 + k, 16'h7C00, 1'b0, 0, '0);
        wr(1'b0, 0, '0, 1'b1, 2, 16'h7FFF);
        wr(1'b0, 0, '0, 1'b1, 3, 16'h8000);
        wr(1'b1, 81, 16'h1234, 1'b1, 9, 16'h4321);
        wr(1'b1, 127, 16'h7FFF, 1'b1, 15, 16'h7FFF);
        run_pass(0, 0, 0);
        chk("s4_h2", HW'(h_out[47:32]), HW'(16'h7FFF));
        chk("s4_h3", HW'(h_out[63:48]), '0);

        // Protocol: start and weight write while busy are ignored
        for (int k = 0; k < 9; k++) mx[k] = '0;
        mx[4] = 16'h0400;
        run_pass(20, 30, 0);
        chk("s5_h0_kept", HW'(h_out[15:0]), HW'(16'h0A00));
        wr(1'b1, 4, 16'h0000, 1'b0, 0, '0);
        run_pass(0, 0, 0);
        chk("s5_h0_new", HW'(h_out[15:0]), HW'(16'h0200));

        // Reset abort mid-pass, then a rerun with cleared arrays
        run_pass(0, 0, 40);
        run_pass(0, 0, 0);
        chk("s6_rerun_zero", h_out, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/q_hidden_layer_mac.md
Name: q_hidden_layer_mac

Overview:
- First fully-connected hidden layer of the DQN forward path.
- Sits directly downstream of the state one-hot encoder and consumes its nine Q6.10 inputs in_layer_1..in_layer_9.
- Computes h[j] = ReLU(sum_i W[j][i]*x[i] + b[j]) serially with one shared multiplier, one MAC per cycle.
- Weights and biases are held in local register arrays loaded through a write port, used by the trainer or initial load.

Parameters:
N_HID, 9, number of hidden neurons
DW, 16, data width, signed Q6.10
FRAC, 10, fractional bits
ACC_W, 40, accumulator width, signed

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request one forward pass; sampled only in IDLE
in_layer_1 .. in_layer_9  in  DW each  signed Q6.10 input vector x[0..8]
w_we  in  1  weight write enable
w_addr  in  clog2(N_HID*9)  weight address = j*9 + i
w_data  in  DW  weight value, signed Q6.10
b_we  in  1  bias write enable
b_addr  in  clog2(N_HID)  bias index j
b_data  in  DW  bias value, signed Q6.10
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse, h_out valid
h_out  out  N_HID*DW  packed activations; h[j] at bits [j*DW +: DW]

Behaviour:
- Reset, asynchronous: FSM to IDLE; busy=0, done=0, h_out=0; all weights, biases, counters and accumulator cleared to 0.
- FSM states: IDLE, MAC, WB, DONE.
- IDLE + start=1:
  - latch all nine inputs into x_reg
  - acc = sext(b[0]) << FRAC; i=0, j=0
  - go to MAC
- MAC:
  - acc += x_reg[i] * W[j][i], full 32-bit signed product, sign-extended to ACC_W
  - i++; when i==8, go to WB
- WB:
  - y = acc >>> FRAC (arithmetic shift, floor rounding)
  - saturate y to [-32768, 32767]
  - ReLU: negative results become 0
  - write y to h[j]
  - if j==N_HID-1 go to DONE; else j++, i=0, acc = sext(b[j+1]) << FRAC, go to MAC
- DONE: done=1 for exactly one cycle, busy drops, return to IDLE.
- Latency: start sampled at edge T; done high in the cycle after edge T + N_HID*10 + 1. With defaults, done is asserted 91 cycles after start.
- h_out updates per neuron during WB. It is guaranteed coherent only when done=1, and holds until the next pass rewrites it.
- start while busy: ignored, with no queuing.
- Inputs changing after start: no effect; x_reg is used for the whole pass.
- w_we / b_we while busy: ignored, so arrays stay stable during a pass. In IDLE, writes take effect on the next edge.
- w_we and b_we in the same IDLE cycle: both writes occur.
- w_addr >= N_HID*9 or b_addr >= N_HID: write dropped.
- start and w_we in the same IDLE cycle: the write lands and the pass starts. The pass uses the new value only if its MAC reads it after the edge; the bench must not rely on this case.
- Reset mid-pass: immediate abort to reset state with no done pulse. Weights are lost and must be reloaded.

Test Plan:
1. Zero pass: after reset, in_layer_5=0x0400, all others 0, pulse start. Required: done exactly at cycle 91, busy high for cycles 1..90, h_out all zero.
2. Positive path: W[0][4]=0x0800 (2.0), b[0]=0x0200 (0.5), in_layer_5=0x0400 (1.0), start. Required: h[0]=0x0A00 (2.5), all other h=0.
3. ReLU clamp: W[1][4]=0xF800 (-2.0), b[1]=0x0100. Same input as scenario 2. Required: h[1]=0x0000. Scenario-2 values still hold, so h[0]=0x0A00.
4. Saturation: all nine inputs 0x7C00 (31.0), W[2][*]=0x7C00, b[2]=0x7FFF. Required: h[2]=0x7FFF. Also b[3]=0x8000 with W[3][*]=0: required h[3]=0.
5. Protocol: pulse start again at cycle 20 of a pass, and issue w_we to W[0][4]=0x0000 at cycle 30. Required: a single done at cycle 91, h[0] unchanged at 0x0A00. A new pass after done gives h[0]=0x0200.
6. Reset abort: deassert rst_n asynchronously mid-cycle at cycle 40 of a pass. Required: busy=0 and h_out=0 immediately, no done pulse. A rerun after reset with no loads gives all-zero h_out.
